// File: rtl/serial_link_pkg.sv
// Shared definitions for the shift-register serial link: receiver state
// encoding, line-level constants and the even-parity helper. The matching
// transmitter imports the same package.
package serial_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic LINE_IDLE = 1'b1;

  // Returns 1 when the data bits plus the parity bit have odd weight, i.e.
  // an even-parity check fails. Unused upper word bits must be zero.
  function automatic logic even_parity_err(input logic [15:0] word, input logic par);
    return (^word) ^ par;
  endfunction

endpackage

// File: rtl/rx_shift_reg.sv
// Serial-in, shift-right register: on each enabled cycle the serial bit
// enters at the MSB and every other bit moves one place towards the LSB,
// so after DATA_W shifts the first bit received sits in bit 0.
module rx_shift_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              shift_en,
  input  logic              sin,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] q_q;

  generate
    if (DATA_W == 1) begin : g_single
      // Single-bit register simply captures the line.
      always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n)      q_q <= '0;
        else if (shift_en) q_q <= sin;
      end
    end else begin : g_multi
      // Shift right, serial data in at the MSB.
      // NOTE: state is cleared by the async reset and updated only with
      // non-blocking assignments, so every reader sees the pre-edge value.
      always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n)      q_q <= '0;
        else if (shift_en) q_q <= {sin, q_q[DATA_W-1:1]};
      end
    end
  endgenerate

  assign q = q_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Receiver for the shift-register serial link. Samples the line on each
// bit strobe, deserializes a start/data/stop frame (LSB first), checks
// framing and hands the word to the consumer over a valid/rd handshake.
// Optional even-parity bit after the data: define RX_PARITY_EN.
module serial_frame_rx
  import serial_link_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              sin,
  input  logic              bit_en,
  input  logic              rd,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              shift_en;
  logic              commit;
  logic [DATA_W-1:0] shreg;
`ifdef RX_PARITY_EN
  logic              par_err_q, par_err_d;
`endif

  rx_shift_reg #(.DATA_W(DATA_W)) u_shreg (
    .clk      (clk),
    .clear_n  (clear_n),
    .shift_en (shift_en),
    .sin      (sin),
    .q        (shreg)
  );

  // Frame FSM: next state, bit counter, shift enable and framing verdict.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_en    = 1'b0;
    frame_err_d = 1'b0;
    commit      = 1'b0;
`ifdef RX_PARITY_EN
    par_err_d   = par_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bit_en && sin == START_BIT) begin
          state_d = DATA;
          cnt_d   = '0;
`ifdef RX_PARITY_EN
          par_err_d = 1'b0;
`endif
        end
      end
      DATA: begin
        if (bit_en) begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
`ifdef RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
      PARITY: begin
`ifdef RX_PARITY_EN
        if (bit_en) begin
          par_err_d = even_parity_err(16'(shreg), sin);
          state_d   = STOP;
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (bit_en) begin
          if (sin == STOP_BIT) begin
            state_d = IDLE;
`ifdef RX_PARITY_EN
            if (par_err_q) frame_err_d = 1'b1;
            else           commit      = 1'b1;
`else
            commit = 1'b1;
`endif
          end else begin
            // Line still low at the stop position: treat as a break.
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end
      BREAK: begin
        if (bit_en && sin == LINE_IDLE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output word, valid flag and overrun flag from commits and pops.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (commit) begin
      // A pop on the commit cycle frees the slot, so the new word lands.
      if (!valid_q || rd) begin
        data_d  = shreg;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rd && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // State and handshake registers.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef RX_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx. Expected words are queued when a
// good frame is driven and popped when the receiver raises/updates data.
module tb_serial_frame_rx;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              clear_n;
  logic              sin;
  logic              bit_en;
  logic              rd;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              frame_err;
  logic              overrun;
  logic              busy;

  int errors = 0;
  int checks = 0;
  int fe_pulses = 0;
  logic [DATA_W-1:0] exp_q[$];

  serial_frame_rx #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .sin       (sin),
    .bit_en    (bit_en),
    .rd        (rd),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_err) fe_pulses++;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // One strobed line bit, driven at a falling edge, then gap idle cycles.
  task automatic send_bit(input logic b, input int gap);
    sin    = b;
    bit_en = 1'b1;
    @(negedge clk);
    bit_en = 1'b0;
    sin    = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  // Full frame; returns at the falling edge right after the stop strobe.
  task automatic send_frame(input logic [7:0] w, input logic stop_b, input logic par_flip,
                            input int gap, input logic rd_on_stop);
    send_bit(1'b0, gap);
    for (int i = 0; i < DATA_W; i++) send_bit(w[i], gap);
`ifdef RX_PARITY_EN
    send_bit((^w) ^ par_flip, gap);
`endif
    rd = rd_on_stop;
    send_bit(stop_b, 0);
    rd = 1'b0;
  endtask

  task automatic do_rd();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] exp_w;
    clear_n = 1'b0; sin = 1'b1; bit_en = 1'b0; rd = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({data, valid, frame_err, overrun, busy} !== '0) begin
      errors++;
      $display("FAIL reset_idle: data=%h valid=%b ferr=%b ovr=%b busy=%b expected all 0",
               data, valid, frame_err, overrun, busy);
    end
    clear_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b0, 0, 1'b0);
    checks++;
    exp_w = exp_q.pop_front();
    if (valid !== 1'b1 || data !== exp_w) begin
      errors++;
      $display("FAIL reset_pre_word: valid=%b data=%h expected valid=1 data=%h", valid, data, exp_w);
    end
    // Start bit plus three data bits, then reset mid-frame.
    send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_midframe_busy: busy=%b expected 1", busy);
    end
    #2 clear_n = 1'b0;
    #1;
    checks++;
    if ({data, valid, frame_err, overrun, busy} !== '0) begin
      errors++;
      $display("FAIL reset_async: data=%h valid=%b ferr=%b ovr=%b busy=%b expected all 0",
               data, valid, frame_err, overrun, busy);
    end
    @(negedge clk);
    clear_n = 1'b1;
    @(negedge clk);
    exp_q.delete();
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0, 0, 1'b0);
    checks++;
    exp_w = exp_q.pop_front();
    if (valid !== 1'b1 || data !== exp_w) begin
      errors++;
      $display("FAIL reset_next_frame: valid=%b data=%h expected valid=1 data=%h", valid, data, exp_w);
    end
    do_rd();
  endtask

  task automatic test_basic();
    logic [7:0] w = 8'hA5;
    logic [7:0] exp_w;
    int fe0 = fe_pulses;
    exp_q.push_back(w);
    send_bit(1'b0, 2);
    for (int i = 0; i < DATA_W; i++) send_bit(w[i], 2);
`ifdef RX_PARITY_EN
    send_bit(^w, 2);
`endif
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_pre_stop: valid=%b expected 0", valid);
    end
    send_bit(1'b1, 0);
    checks++;
    exp_w = exp_q.pop_front();
    if (valid !== 1'b1 || data !== exp_w) begin
      errors++;
      $display("FAIL basic_word: valid=%b data=%h expected valid=1 data=%h", valid, data, exp_w);
    end
    checks++;
    if (fe_pulses !== fe0) begin
      errors++;
      $display("FAIL basic_no_ferr: pulses=%0d expected %0d", fe_pulses, fe0);
    end
  endtask

  // Entered with valid=1, data=0xA5 left by test_basic.
  task automatic test_frame_err();
    logic [7:0] exp_w;
    send_frame(8'h99, 1'b0, 1'b0, 0, 1'b0);
    checks++;
    if (frame_err !== 1'b1 || valid !== 1'b1 || data !== 8'hA5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ferr_pulse: ferr=%b valid=%b data=%h busy=%b expected 1 1 a5 1",
               frame_err, valid, data, busy);
    end
    @(negedge clk);
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL ferr_width: ferr=%b expected 0", frame_err);
    end
    repeat (5) send_bit(1'b0, 1);
    checks++;
    if (valid !== 1'b1 || data !== 8'hA5 || overrun !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ferr_break_hold: valid=%b data=%h ovr=%b busy=%b expected 1 a5 0 1",
               valid, data, overrun, busy);
    end
    send_bit(1'b1, 0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ferr_break_exit: busy=%b expected 0", busy);
    end
    do_rd();
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0, 0, 1'b0);
    checks++;
    exp_w = exp_q.pop_front();
    if (valid !== 1'b1 || data !== exp_w) begin
      errors++;
      $display("FAIL ferr_recover: valid=%b data=%h expected valid=1 data=%h", valid, data, exp_w);
    end
    do_rd();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_w;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0, 0, 1'b0);
    checks++;
    exp_w = exp_q.pop_front();
    if (valid !== 1'b1 || data !== exp_w) begin
      errors++;
      $display("FAIL b2b_first: valid=%b data=%h expected valid=1 data=%h", valid, data, exp_w);
    end
    // Start bit of the second frame on the very next strobe; it is dropped.
    send_frame(8'h22, 1'b1, 1'b0, 0, 1'b0);
    checks++;
    if (valid !== 1'b1 || data !== 8'h11 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL b2b_overrun: valid=%b data=%h ovr=%b expected 1 11 1", valid, data, overrun);
    end
    do_rd();
    checks++;
    if (valid !== 1'b0 || overrun !== 1'b0 || data !== 8'h11) begin
      errors++;
      $display("FAIL b2b_pop: valid=%b ovr=%b data=%h expected 0 0 11", valid, overrun, data);
    end
  endtask

  task automatic test_simul_rd();
    logic [7:0] exp_w;
    exp_q.push_back(8'h66);
    send_frame(8'h66, 1'b1, 1'b0, 0, 1'b0);
    checks++;
    exp_w = exp_q.pop_front();
    if (valid !== 1'b1 || data !== exp_w) begin
      errors++;
      $display("FAIL simul_first: valid=%b data=%h expected valid=1 data=%h", valid, data, exp_w);
    end
    exp_q.push_back(8'h77);
    send_frame(8'h77, 1'b1, 1'b0, 1, 1'b1);
    checks++;
    exp_w = exp_q.pop_front();
    if (valid !== 1'b1 || data !== exp_w || overrun !== 1'b0) begin
      errors++;
      $display("FAIL simul_rd_commit: valid=%b data=%h ovr=%b expected 1 %h 0",
               valid, data, overrun, exp_w);
    end
    do_rd();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL simul_final_pop: valid=%b expected 0", valid);
    end
  endtask

`ifdef RX_PARITY_EN
  task automatic test_parity();
    logic [7:0] exp_w;
    send_frame(8'h03, 1'b1, 1'b1, 0, 1'b0);
    checks++;
    if (frame_err !== 1'b1 || valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL parity_bad: ferr=%b valid=%b busy=%b expected 1 0 0", frame_err, valid, busy);
    end
    exp_q.push_back(8'h03);
    send_frame(8'h03, 1'b1, 1'b0, 0, 1'b0);
    checks++;
    exp_w = exp_q.pop_front();
    if (valid !== 1'b1 || data !== exp_w || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_good: valid=%b data=%h ferr=%b expected 1 %h 0",
               valid, data, frame_err, exp_w);
    end
    do_rd();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_frame_err();
    test_back_to_back();
    test_simul_rd();
`ifdef RX_PARITY_EN
    test_parity();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d words left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
